// File: rtl/mdu_sequencer.sv
// Multi-cycle unsigned multiply/divide unit producing HI/LO for the MIPS core.
// One shift-add or restoring-divide iteration per cycle on a single shared adder.
module mdu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned SUM_W = WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic               dbz_d, busy_d, done_d, last;
  logic [WIDTH:0]     rem_sh, add_a, add_b;
  logic               add_cin;
  logic [SUM_W-1:0]   sum;

  // Shared adder: accumulate for MULTU, trial subtract (carry out = no borrow) for DIVU.
  always_comb begin
    rem_sh = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
    if (state_q == S_DIV) begin
      add_a   = rem_sh;
      add_b   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc_q[ACC_W-1:WIDTH]};
      add_b   = acc_q[0] ? {1'b0, opnd_q} : '0;
      add_cin = 1'b0;
    end
    sum = {1'b0, add_a} + {1'b0, add_b} + SUM_W'(add_cin);
    if (state_q == S_DIV) begin
      if (sum[WIDTH+1]) acc_step = {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else              acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi;
    lo_d    = lo;
    dbz_d   = div_by_zero;
    last    = (cnt_q == CNT_W'(WIDTH - 1));
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          opnd_d  = op ? rt_val : rs_val;
          acc_d   = {{WIDTH{1'b0}}, (op ? rs_val : rt_val)};
          cnt_d   = '0;
          dbz_d   = op && (rt_val == '0);
          state_d = op ? S_DIV : S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          hi_d    = acc_step[ACC_W-1:WIDTH];
          lo_d    = acc_step[WIDTH-1:0];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      hi          <= hi_d;
      lo          <= lo_d;
      div_by_zero <= dbz_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer: latency, results, ignore/back-to-back, reset.
module tb_mdu_sequencer;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int checks = 0;
  int errors = 0;

  mdu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Present a request for one edge; returns at the falling edge of cycle 1.
  task automatic drive_start(input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; lat is the cycle number where done was seen.
  task automatic wait_done(input int from, output int lat, output int busy_n);
    lat = from;
    busy_n = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; rs_val = '0; rt_val = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b hi=%h lo=%h, required all zero",
               busy, done, div_by_zero, hi, lo);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_multu;
    logic [WIDTH-1:0] va [3] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [WIDTH-1:0] vb [3] = '{32'd6, 32'hFFFF_FFFF, 32'd2};
    logic [WIDTH-1:0] eh [3] = '{32'h0, 32'hFFFF_FFFE, 32'h1};
    logic [WIDTH-1:0] el [3] = '{32'h2A, 32'h1, 32'h0};
    int lat, bn;
    for (int i = 0; i < 3; i++) begin
      drive_start(1'b0, va[i], vb[i]);
      wait_done(1, lat, bn);
      checks++;
      if (lat != 33 || bn != 32) begin
        errors++;
        $display("FAIL multu_timing[%0d]: done_cycle=%0d busy_cycles=%0d, required 33/32", i, lat, bn);
      end
      checks++;
      if (hi !== eh[i] || lo !== el[i] || busy !== 1'b0) begin
        errors++;
        $display("FAIL multu_result[%0d]: hi=%h lo=%h busy=%b, required hi=%h lo=%h busy=0",
                 i, hi, lo, busy, eh[i], el[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || hi !== eh[i] || lo !== el[i]) begin
        errors++;
        $display("FAIL multu_hold[%0d]: done=%b hi=%h lo=%h, required done=0 hi=%h lo=%h",
                 i, done, hi, lo, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_divu;
    int lat, bn;
    drive_start(1'b1, 32'd100, 32'd7);
    wait_done(1, lat, bn);
    checks++;
    if (lat != 33 || lo !== 32'd14 || hi !== 32'd2 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL divu_100_7: cycle=%0d lo=%0d hi=%0d dbz=%b, required 33/14/2/0",
               lat, lo, hi, div_by_zero);
    end
    drive_start(1'b1, 32'h1234, 32'd0);
    checks++;
    if (div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL divu_dbz_flag: dbz=%b, required 1", div_by_zero);
    end
    wait_done(1, lat, bn);
    checks++;
    if (lat != 33 || bn != 32 || lo !== 32'hFFFF_FFFF || hi !== 32'h1234 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL divu_by_zero: cycle=%0d busy=%0d lo=%h hi=%h dbz=%b, required 33/32/ffffffff/00001234/1",
               lat, bn, lo, hi, div_by_zero);
    end
    drive_start(1'b0, 32'd3, 32'd3);
    wait_done(1, lat, bn);
    checks++;
    if (div_by_zero !== 1'b0 || lo !== 32'd9 || hi !== 32'd0) begin
      errors++;
      $display("FAIL dbz_clear: dbz=%b lo=%0d hi=%0d, required 0/9/0", div_by_zero, lo, hi);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    drive_start(1'b0, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy: busy=%b done=%b, required 1/0", busy, done);
    end
    repeat (14) @(negedge clk);
    start = 1'b1; op = 1'b0; rs_val = 32'd9; rt_val = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(21, lat, bn);
    checks++;
    if (lat != 33 || bn != 12 || lo !== 32'd15 || hi !== 32'd0) begin
      errors++;
      $display("FAIL ignore_result: cycle=%0d busy=%0d lo=%0d hi=%0d, required 33/12/15/0", lat, bn, lo, hi);
    end
    start = 1'b1; op = 1'b1; rs_val = 32'd9; rt_val = 32'd2;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy: busy=%b done=%b, required 1/0", busy, done);
    end
    wait_done(1, lat, bn);
    checks++;
    if (lat != 33 || lo !== 32'd4 || hi !== 32'd1) begin
      errors++;
      $display("FAIL b2b_result: cycle=%0d lo=%0d hi=%0d, required 33/4/1", lat, lo, hi);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bn, seen;
    drive_start(1'b0, 32'd7, 32'd6);
    wait_done(1, lat, bn);
    checks++;
    if (lo !== 32'd42) begin
      errors++;
      $display("FAIL pre_reset_result: lo=%0d, required 42", lo);
    end
    @(negedge clk);
    drive_start(1'b0, 32'd5, 32'd5);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0", busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || lo !== '0) begin
      errors++;
      $display("FAIL post_reset_quiet: active_cycles=%0d lo=%h, required 0/0", seen, lo);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_divu();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide unit for the MIPS core: accepts a MULTU or DIVU request from the decode stage (driven by the control unit's `mult_we` strobe), runs a WIDTH-iteration shift-add multiply or restoring divide on an internal shared adder, and writes the HI/LO registers. While it runs, it stalls the core through `busy`. HI/LO are read combinationally by the result mux for MFHI/MFLO.

## Interface

Parameters:
- `WIDTH`, 32, operand width. HI and LO are each WIDTH bits.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request strobe (control unit `mult_we`). Sampled only in IDLE or DONE.
- `op` input 1: 0 = MULTU, 1 = DIVU. Sampled with `start`.
- `rs_val` input WIDTH: multiplicand, or dividend for DIVU.
- `rt_val` input WIDTH: multiplier, or divisor for DIVU.
- `busy` output 1: iteration in progress. Drives the pipeline stall.
- `done` output 1: one-cycle pulse; HI/LO are valid from this cycle onward.
- `div_by_zero` output 1: registered. Set when the last accepted DIVU had `rt_val == 0`.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation

States: IDLE, MUL, DIV, DONE. A 6-bit iteration counter `cnt` runs from 0 to WIDTH-1.

IDLE:
- `start` = 1 with `op` = 0: latch operands, clear the 2·WIDTH accumulator, `cnt` ← 0, go to MUL.
- `start` = 1 with `op` = 1: latch operands, clear the partial remainder, `cnt` ← 0, go to DIV.
- `div_by_zero` is updated at acceptance: 1 if DIVU and `rt_val` == 0, else 0.

MUL, one iteration per cycle (unsigned shift-add):
- If the multiplier LSB is 1, add the multiplicand to the accumulator upper half.
- Shift the {carry, accumulator} right by 1.

DIV, one iteration per cycle (unsigned restoring):
- Shift {rem, quotient} left by 1.
- Trial subtract `rem − divisor` at WIDTH+1 bits.
- If the result is non-negative, commit it and set quotient LSB = 1.

Completion:
- When `cnt` == WIDTH-1, the iteration completes and on that edge writes HI/LO, then goes to DONE.
- MULTU result: HI = product[2W-1:W], LO = product[W-1:0].
- DIVU result: HI = remainder, LO = quotient.
- Divide by zero needs no special datapath. The algorithm yields LO = all ones and HI = dividend in the normal WIDTH cycles.

DONE:
- `done` = 1 for one cycle.
- `start` = 1 is accepted exactly as in IDLE, so back-to-back requests lose no cycle.
- Otherwise go to IDLE.

Other rules:
- `start` while in MUL or DIV is ignored; operands and `op` are not re-sampled.
- HI/LO hold their value in all states except on the final-iteration edge.
- `busy` = 1 exactly in MUL and DIV (decoded from state, glitch-free registered state).
- `done` = 1 exactly in DONE.

Reset (`rst_n` low, any time including mid-operation):
- State → IDLE, `cnt` = 0.
- `hi` = 0, `lo` = 0, `div_by_zero` = 0.
- Accumulator and operand registers cleared.
- `busy` = 0, `done` = 0.
- An interrupted operation produces no result. Release is synchronous to the next edge.

## Timing

- Cycle 0: `start` sampled high in IDLE/DONE.
- Cycles 1..WIDTH: `busy` = 1 (32 cycles at the default width).
- Cycle WIDTH+1: `busy` = 0, `done` = 1, `hi`/`lo` hold the result.
- Fixed latency of WIDTH+1 cycles for both operations, independent of operand values.
- Back-to-back: with `start` high in cycle WIDTH+1, `busy` is high again in cycle WIDTH+2.
- No combinational path from `start`/`op`/operands to any output.

## Test plan

- MULTU 7 × 6, `start` pulse at cycle 0:
  - `busy` high cycles 1–32.
  - `done` at cycle 33.
  - `hi` = 0x00000000, `lo` = 0x0000002A.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 0x00000001. Also 0x80000000 × 2 → `hi` = 1, `lo` = 0.
- DIVU 100 / 7:
  - `lo` = 14, `hi` = 2, `div_by_zero` = 0, `done` at cycle 33.
- DIVU 0x1234 / 0:
  - `lo` = 0xFFFFFFFF, `hi` = 0x00001234, `div_by_zero` = 1, latency unchanged.
  - A following MULTU clears `div_by_zero` to 0.
- `start` re-asserted with new operands at cycles 5 and 20 of a MULTU 3 × 5:
  - Ignored; result `lo` = 15.
  - `start` held in the DONE cycle with DIVU 9/2 → `busy` next cycle, then `lo` = 4, `hi` = 1.
- `rst_n` pulled low at cycle 10 of a MULTU after a prior result of `lo` = 42:
  - Immediately `busy` = 0, `hi` = `lo` = 0.
  - After release, no `done` until a new `start`.
